// File: rtl/saf_fifo_pkg.sv
// rtl/saf_fifo_pkg.sv - shared types and constants for the store-and-forward FIFO controller
package saf_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DROP = 2'd2
   } saf_state_t;

   localparam int STATS_W = 16;

   // One extra bit over the index so full and empty are distinguishable.
   function automatic int ptr_width(input int depth_lg2);
      return depth_lg2 + 1;
   endfunction

endpackage

// File: rtl/saf_fifo_mem.sv
// rtl/saf_fifo_mem.sv - simple dual-port storage, one write port and one combinational read port
module saf_fifo_mem #(
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 33
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [1<<ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/saf_fifo_ctrl.sv
// rtl/saf_fifo_ctrl.sv - store-and-forward FIFO: packets become readable only once committed clean
// Optional SAF_FIFO_CTRL_STATS_EN adds saturating drop/commit counters.
module saf_fifo_ctrl
   import saf_fifo_pkg::*;
#(
   parameter int DEPTH_LG2  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  wlast_i,
   input  logic                  werror_i,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rlast_o,
   output logic                  commit_o,
   output logic                  drop_o,
   output logic [DEPTH_LG2:0]    pkt_cnt_o
`ifdef SAF_FIFO_CTRL_STATS_EN
  ,output logic [STATS_W-1:0]    drop_cnt_o,
   output logic [STATS_W-1:0]    commit_cnt_o
`endif
);

   localparam int PW = ptr_width(DEPTH_LG2);
   localparam logic [PW-1:0] DEPTH_V = {1'b1, {DEPTH_LG2{1'b0}}};
   localparam logic [PW-1:0] ONE     = PW'(1);

   saf_state_t      state;
   logic [PW-1:0]   wr_ptr, cmt_ptr, rd_ptr;
   logic            full, spec_full;
   logic            wr_fire, discard, mem_we, cmt_evt, rd_fire, rlast_evt;
   logic [DATA_WIDTH:0] rd_entry;

   assign full      = (wr_ptr - rd_ptr) == DEPTH_V;
   assign spec_full = (wr_ptr - cmt_ptr) == DEPTH_V;

   // Overflowing a packet must never stall the writer, otherwise the
   // oversize packet could never finish and be discarded.
   assign wready_o  = (state == DROP) || spec_full || !full;

   assign wr_fire   = wvalid_i && wready_o;
   assign discard   = (state == DROP) || spec_full || werror_i;
   assign mem_we    = wr_fire && !discard;
   assign cmt_evt   = mem_we && wlast_i;

   assign rvalid_o  = rd_ptr != cmt_ptr;
   assign rd_fire   = rvalid_o && rready_i;
   assign rlast_evt = rd_fire && rlast_o;
   assign rlast_o   = rd_entry[DATA_WIDTH];
   assign rdata_o   = rd_entry[DATA_WIDTH-1:0];

   saf_fifo_mem #(
      .ADDR_W (DEPTH_LG2),
      .WIDTH  (DATA_WIDTH + 1)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr[DEPTH_LG2-1:0]),
      .wdata ({wlast_i, wdata_i}),
      .raddr (rd_ptr[DEPTH_LG2-1:0]),
      .rdata (rd_entry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         cmt_ptr   <= '0;
         rd_ptr    <= '0;
         commit_o  <= 1'b0;
         drop_o    <= 1'b0;
         pkt_cnt_o <= '0;
      end else begin
         commit_o <= 1'b0;
         drop_o   <= 1'b0;
         if (wr_fire) begin
            if (state == DROP) begin
               if (wlast_i) begin
                  drop_o <= 1'b1;
                  state  <= IDLE;
               end
            end else if (discard) begin
               // Rewind the speculative pointer; the partial packet vanishes.
               wr_ptr <= cmt_ptr;
               if (wlast_i) begin
                  drop_o <= 1'b1;
                  state  <= IDLE;
               end else begin
                  state  <= DROP;
               end
            end else begin
               wr_ptr <= wr_ptr + ONE;
               if (wlast_i) begin
                  cmt_ptr  <= wr_ptr + ONE;
                  commit_o <= 1'b1;
                  state    <= IDLE;
               end else begin
                  state    <= FILL;
               end
            end
         end
         if (rd_fire) rd_ptr <= rd_ptr + ONE;
         if (cmt_evt && !rlast_evt)      pkt_cnt_o <= pkt_cnt_o + ONE;
         else if (!cmt_evt && rlast_evt) pkt_cnt_o <= pkt_cnt_o - ONE;
      end
   end

`ifdef SAF_FIFO_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_o   <= '0;
         commit_cnt_o <= '0;
      end else begin
         if (drop_o && (drop_cnt_o != '1))     drop_cnt_o   <= drop_cnt_o + STATS_W'(1);
         if (commit_o && (commit_cnt_o != '1)) commit_cnt_o <= commit_cnt_o + STATS_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_saf_fifo_ctrl.sv
// tb/tb_saf_fifo_ctrl.sv - self-checking bench for saf_fifo_ctrl with a queue-based packet model
module tb_saf_fifo_ctrl;

   localparam int DL    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << DL;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wvalid_i = 1'b0, wlast_i = 1'b0, werror_i = 1'b0, rready_i = 1'b0;
   logic [DW-1:0] wdata_i = '0;
   logic          wready_o, rvalid_o, rlast_o, commit_o, drop_o;
   logic [DW-1:0] rdata_o;
   logic [DL:0]   pkt_cnt_o;

   saf_fifo_ctrl #(.DEPTH_LG2(DL), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wvalid_i  (wvalid_i),
      .wready_o  (wready_o),
      .wdata_i   (wdata_i),
      .wlast_i   (wlast_i),
      .werror_i  (werror_i),
      .rvalid_o  (rvalid_o),
      .rready_i  (rready_i),
      .rdata_o   (rdata_o),
      .rlast_o   (rlast_o),
      .commit_o  (commit_o),
      .drop_o    (drop_o),
      .pkt_cnt_o (pkt_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   beat_t cq[$];
   beat_t pend[$];
   bit    dropping = 0;
   bit    exp_commit = 0, exp_drop = 0;
   int    checks = 0, errors = 0;

   typedef struct {
      logic          wv;
      logic [DW-1:0] wd;
      logic          wl, we, rr;
      logic          c, d, v;
      logic [DW-1:0] rd;
      logic          rl;
      int            pk;
   } vec_t;

   vec_t vt[11];

   function automatic vec_t mkv(logic wv, logic [DW-1:0] wd, logic wl, logic we, logic rr,
                                logic c, logic d, logic v, logic [DW-1:0] rd, logic rl, int pk);
      vec_t r;
      r.wv = wv; r.wd = wd; r.wl = wl; r.we = we; r.rr = rr;
      r.c = c; r.d = d; r.v = v; r.rd = rd; r.rl = rl; r.pk = pk;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_wready();
      return dropping || (pend.size() == DEPTH) || ((pend.size() + cq.size()) < DEPTH);
   endfunction

   function automatic int model_pkts();
      int n = 0;
      foreach (cq[i]) if (cq[i].last) n++;
      return n;
   endfunction

   task automatic check_model();
      chk("m_wready", wready_o, model_wready());
      chk("m_rvalid", rvalid_o, cq.size() > 0);
      if (cq.size() > 0) begin
         chk("m_rdata", rdata_o, cq[0].data);
         chk("m_rlast", rlast_o, cq[0].last);
      end
      chk("m_commit", commit_o, exp_commit);
      chk("m_drop", drop_o, exp_drop);
      chk("m_pkt_cnt", pkt_cnt_o, model_pkts());
   endtask

   task automatic model_step(input logic wv, input logic [DW-1:0] wd, input logic wl,
                             input logic we, input logic rr);
      bit acc = wv && model_wready();
      bit rd  = rr && (cq.size() > 0);
      beat_t b;
      exp_commit = 0;
      exp_drop   = 0;
      if (rd) void'(cq.pop_front());
      if (acc) begin
         if (dropping) begin
            if (wl) begin dropping = 0; exp_drop = 1; end
         end else if ((pend.size() == DEPTH) || we) begin
            pend.delete();
            if (wl) exp_drop = 1;
            else    dropping = 1;
         end else begin
            b.last = wl;
            b.data = wd;
            pend.push_back(b);
            if (wl) begin
               foreach (pend[i]) cq.push_back(pend[i]);
               pend.delete();
               exp_commit = 1;
            end
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic wl,
                        input logic we, input logic rr);
      check_model();
      wvalid_i = wv; wdata_i = wd; wlast_i = wl; werror_i = we; rready_i = rr;
      model_step(wv, wd, wl, we, rr);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      repeat (DEPTH + 4) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // clean 3-beat packet read back-to-back, then a 4-beat packet errored on beat 2
      vt[0]  = mkv(1, 32'hA, 0, 0, 1,  0, 0, 0, 32'h0, 0, 0);
      vt[1]  = mkv(1, 32'hB, 0, 0, 1,  0, 0, 0, 32'h0, 0, 0);
      vt[2]  = mkv(1, 32'hC, 1, 0, 1,  1, 0, 1, 32'hA, 0, 1);
      vt[3]  = mkv(0, 32'h0, 0, 0, 1,  0, 0, 1, 32'hB, 0, 1);
      vt[4]  = mkv(0, 32'h0, 0, 0, 1,  0, 0, 1, 32'hC, 1, 1);
      vt[5]  = mkv(0, 32'h0, 0, 0, 1,  0, 0, 0, 32'h0, 0, 0);
      vt[6]  = mkv(1, 32'h1, 0, 0, 1,  0, 0, 0, 32'h0, 0, 0);
      vt[7]  = mkv(1, 32'h2, 0, 1, 1,  0, 0, 0, 32'h0, 0, 0);
      vt[8]  = mkv(1, 32'h3, 0, 0, 1,  0, 0, 0, 32'h0, 0, 0);
      vt[9]  = mkv(1, 32'h4, 1, 0, 1,  0, 1, 0, 32'h0, 0, 0);
      vt[10] = mkv(0, 32'h0, 0, 0, 1,  0, 0, 0, 32'h0, 0, 0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_wready", wready_o, 1);
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_commit", commit_o, 0);
      chk("rst_drop", drop_o, 0);
      chk("rst_pkt_cnt", pkt_cnt_o, 0);

      foreach (vt[i]) begin
         drive(vt[i].wv, vt[i].wd, vt[i].wl, vt[i].we, vt[i].rr);
         chk($sformatf("tbl%0d_commit", i), commit_o, vt[i].c);
         chk($sformatf("tbl%0d_drop", i), drop_o, vt[i].d);
         chk($sformatf("tbl%0d_rvalid", i), rvalid_o, vt[i].v);
         chk($sformatf("tbl%0d_pkt_cnt", i), pkt_cnt_o, vt[i].pk);
         if (vt[i].v) begin
            chk($sformatf("tbl%0d_rdata", i), rdata_o, vt[i].rd);
            chk($sformatf("tbl%0d_rlast", i), rlast_o, vt[i].rl);
         end
      end

      // 17-beat packet into an empty FIFO overflows on the last beat
      for (int i = 1; i <= DEPTH + 1; i++) begin
         if (i == DEPTH + 1) chk("ovf_wready_spec_full", wready_o, 1);
         drive(1'b1, DW'(i), i == DEPTH + 1, 1'b0, 1'b0);
      end
      chk("ovf_drop", drop_o, 1);
      chk("ovf_rvalid", rvalid_o, 0);
      drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
      chk("ovf_next_commit", commit_o, 1);
      chk("ovf_next_rdata0", rdata_o, 32'h11);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("ovf_next_rdata1", rdata_o, 32'h22);
      chk("ovf_next_rlast1", rlast_o, 1);
      drain();

      // fill with committed packets: stall, no drop
      for (int p = 0; p < 4; p++)
         for (int b = 0; b < 4; b++)
            drive(1'b1, DW'(32'h100 + p * 4 + b), b == 3, 1'b0, 1'b0);
      chk("full_wready", wready_o, 0);
      chk("full_pkt_cnt", pkt_cnt_o, 4);
      drive(1'b1, 32'h99, 1'b1, 1'b0, 1'b0);
      chk("full_no_drop", drop_o, 0);
      chk("full_no_commit", commit_o, 0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("full_release_wready", wready_o, 1);
      drain();

      // commit of packet 2 on the same edge as the rlast read of packet 1
      drive(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h32, 1'b1, 1'b0, 1'b0);
      chk("same_pkt_before", pkt_cnt_o, 1);
      drive(1'b1, 32'h41, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 32'h42, 1'b1, 1'b0, 1'b1);
      chk("same_commit", commit_o, 1);
      chk("same_pkt_after", pkt_cnt_o, 1);
      chk("same_rdata", rdata_o, 32'h41);
      drain();

      // asynchronous reset mid-packet with committed data present
      drive(1'b1, 32'h51, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h61, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h62, 1'b0, 1'b0, 1'b0);
      wvalid_i = 1'b0; rready_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wready", wready_o, 1);
      chk("arst_rvalid", rvalid_o, 0);
      chk("arst_commit", commit_o, 0);
      chk("arst_drop", drop_o, 0);
      chk("arst_pkt_cnt", pkt_cnt_o, 0);
      cq.delete(); pend.delete(); dropping = 0; exp_commit = 0; exp_drop = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'h71, 1'b1, 1'b0, 1'b0);
      chk("post_rst_commit", commit_o, 1);
      chk("post_rst_rdata", rdata_o, 32'h71);
      chk("post_rst_rlast", rlast_o, 1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("post_rst_rvalid", rvalid_o, 0);
      chk("post_rst_drop", drop_o, 0);

      // randomized traffic against the model: slow reader, then fast reader
      for (int ph = 0; ph < 2; ph++) begin
         repeat (1500) begin
            logic rr;
            rr = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0, rr);
         end
      end
      wvalid_i = 1'b0;
      drain();
      check_model();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
